// File: rtl/ibex_instr_iob_pkg.sv
// ---------------------------------------------------------------------------
// ibex_instr_iob_pkg : shared types and widths for the instruction IOb bridge
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ibex_instr_iob_pkg;

  localparam int unsigned IOB_ADDR_W = 32;
  localparam int unsigned IOB_DATA_W = 32;

  // Kind of traffic currently outstanding; bus and local errors never mix.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ERR  = 2'd2
  } mode_e;

endpackage : ibex_instr_iob_pkg

`default_nettype wire

// File: rtl/ibex_instr_iob_bridge.sv
// ---------------------------------------------------------------------------
// ibex_instr_iob_bridge : prefetch req/gnt/rvalid to IOb read bridge
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ibex_instr_iob_bridge
  import ibex_instr_iob_pkg::*;
#(
  parameter int unsigned           NUM_REQS = 2,
  parameter logic [IOB_ADDR_W-1:0] MemBase  = 32'h0000_0000,
  parameter logic [IOB_ADDR_W-1:0] MemSize  = 32'h0001_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  instr_req_i,
  input  logic [IOB_ADDR_W-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [IOB_DATA_W-1:0] instr_rdata_o,
  output logic                  instr_err_o,
  output logic                  iob_valid_o,
  output logic [IOB_ADDR_W-1:0] iob_addr_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [IOB_DATA_W-1:0] iob_rdata_i,
  output logic                  busy_o
);

  localparam int unsigned     CNT_W   = $clog2(NUM_REQS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_REQS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic             err_pend_q, err_pend_d;

  logic w_in_range;
  logic w_eligible;
  logic w_gnt;
  logic w_bus_gnt;
  logic w_err_gnt;
  logic w_bus_rsp;

  // Offset compare handles windows that start above zero without a lower bound check.
  assign w_in_range = (instr_addr_i - MemBase) < MemSize;

  assign w_eligible = instr_req_i &
                      (w_in_range ? ((mode_q != ERR) && (cnt_q < MAX_CNT))
                                  : ((cnt_q == '0) && !err_pend_q));

  assign w_gnt     = w_eligible & (w_in_range ? iob_ready_i : 1'b1);
  assign w_bus_gnt = w_gnt & w_in_range;
  assign w_err_gnt = w_gnt & ~w_in_range;
  // A response with nothing outstanding is dropped here.
  assign w_bus_rsp = (mode_q == BUS) && (cnt_q != '0) && iob_rvalid_i;

  assign iob_valid_o    = w_eligible & w_in_range;
  assign iob_addr_o     = {instr_addr_i[IOB_ADDR_W-1:2], 2'b00};
  assign instr_gnt_o    = w_gnt;
  assign instr_rvalid_o = w_bus_rsp | err_pend_q;
  assign instr_rdata_o  = w_bus_rsp ? iob_rdata_i : '0;
  assign instr_err_o    = err_pend_q;
  assign busy_o         = (cnt_q != '0) | err_pend_q | instr_req_i;

  always_comb begin
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    mode_d     = mode_q;

    unique case ({w_bus_gnt, w_bus_rsp})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // The pending error is answered the cycle after its grant, unconditionally.
    if (w_err_gnt) begin
      err_pend_d = 1'b1;
    end else if (err_pend_q) begin
      err_pend_d = 1'b0;
    end

    if (w_bus_gnt) begin
      mode_d = BUS;
    end else if (w_err_gnt) begin
      mode_d = ERR;
    end else if ((cnt_d == '0) && !err_pend_d) begin
      mode_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      mode_q     <= IDLE;
      err_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      err_pend_q <= err_pend_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    assert (!(rst_ni && iob_rvalid_i && (cnt_q == '0)))
      else $warning("stray iob_rvalid_i with no outstanding fetch was dropped");
  end
`endif

endmodule : ibex_instr_iob_bridge

`default_nettype wire

// File: tb/tb_ibex_instr_iob_bridge.sv
// ---------------------------------------------------------------------------
// tb_ibex_instr_iob_bridge : directed bench with a queue-based reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ibex_instr_iob_bridge;

  localparam int unsigned NREQ = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        ready = 1'b0;
  logic        bus_rv = 1'b0;
  logic [31:0] bus_rd = '0;
  logic        gnt, rvalid, err, iobv, busy;
  logic [31:0] rdata, iob_addr;

  int n_cmp = 0;
  int n_bad = 0;

  ibex_instr_iob_bridge #(
    .NUM_REQS(NREQ),
    .MemBase (BASE),
    .MemSize (SIZE)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .instr_req_i   (req),
    .instr_addr_i  (addr),
    .instr_gnt_o   (gnt),
    .instr_rvalid_o(rvalid),
    .instr_rdata_o (rdata),
    .instr_err_o   (err),
    .iob_valid_o   (iobv),
    .iob_addr_o    (iob_addr),
    .iob_ready_i   (ready),
    .iob_rvalid_i  (bus_rv),
    .iob_rdata_i   (bus_rd),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // Outstanding transactions in grant order: 1 = local error, 0 = bus read.
  bit q_err[$];

  typedef struct packed {
    logic        gnt;
    logic        iobv;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
    logic        busy;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    bit   inr, has_err, elig;
    e       = '0;
    inr     = (addr - BASE) < SIZE;
    has_err = (q_err.size() > 0) && q_err[0];
    if (inr) elig = req && !has_err && (q_err.size() < NREQ);
    else     elig = req && (q_err.size() == 0);
    e.iobv = elig && inr;
    e.gnt  = elig && (inr ? ready : 1'b1);
    if (has_err) begin
      e.rv  = 1'b1;
      e.err = 1'b1;
    end else if ((q_err.size() > 0) && bus_rv) begin
      e.rv    = 1'b1;
      e.rdata = bus_rd;
    end
    e.busy = (q_err.size() != 0) || req;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_ni) begin
    exp_t e;
    if (!rst_ni) begin
      q_err.delete();
    end else begin
      e = model_out();
      if (e.rv) void'(q_err.pop_front());
      if (e.gnt) q_err.push_back(!((addr - BASE) < SIZE));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = model_out();
    chk("model_gnt",    32'(gnt),    32'(e.gnt));
    chk("model_iobv",   32'(iobv),   32'(e.iobv));
    chk("model_rvalid", 32'(rvalid), 32'(e.rv));
    chk("model_err",    32'(err),    32'(e.err));
    chk("model_rdata",  rdata,       e.rdata);
    chk("model_busy",   32'(busy),   32'(e.busy));
    if (e.iobv) chk("model_iob_addr", iob_addr, {addr[31:2], 2'b00});
  end

  // Applies one cycle of inputs just after the rising edge, then waits for the sample point.
  task automatic step(input bit r, input logic [31:0] a, input bit rdy,
                      input bit rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    req    = r;
    addr   = a;
    ready  = rdy;
    bus_rv = rv;
    bus_rd = rd;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;

    // Single fetch with a two-cycle bus latency.
    step(1, 32'h104, 1, 0, 0);
    chk("t1_gnt", 32'(gnt), 1);
    chk("t1_iob_addr", iob_addr, 32'h104);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t1_rvalid", 32'(rvalid), 1);
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);
    chk("t1_err", 32'(err), 0);
    step(0, 0, 0, 0, 0);
    chk("t1_idle_busy", 32'(busy), 0);

    // Bus stall: valid without grant, then grant.
    step(1, 32'h203, 0, 0, 0);
    chk("stall_iobv", 32'(iobv), 1);
    chk("stall_gnt", 32'(gnt), 0);
    chk("stall_addr", iob_addr, 32'h200);
    step(1, 32'h203, 1, 0, 0);
    chk("stall_gnt2", 32'(gnt), 1);
    step(0, 0, 0, 1, 32'h1111_2222);
    chk("stall_rdata", rdata, 32'h1111_2222);

    // Back-to-back fetches up to the outstanding limit.
    step(1, 32'h0, 1, 0, 0);
    step(1, 32'h4, 1, 0, 0);
    chk("full_gnt2", 32'(gnt), 1);
    step(1, 32'h8, 1, 0, 0);
    chk("full_iobv", 32'(iobv), 0);
    chk("full_gnt", 32'(gnt), 0);
    step(1, 32'h8, 1, 1, 32'hA0A0_0000);
    chk("full_same_cycle_gnt", 32'(gnt), 0);
    chk("full_rv", 32'(rvalid), 1);
    step(1, 32'h8, 1, 0, 0);
    chk("full_freed_gnt", 32'(gnt), 1);
    step(0, 0, 0, 1, 32'hA0A0_0004);
    step(0, 0, 0, 1, 32'hA0A0_0008);
    chk("full_last_rdata", rdata, 32'hA0A0_0008);
    step(0, 0, 0, 0, 0);
    chk("full_drained_busy", 32'(busy), 0);

    // Out-of-range fetch while idle, first byte past the window.
    step(1, 32'h0001_0000, 0, 0, 0);
    chk("oor_gnt", 32'(gnt), 1);
    chk("oor_iobv", 32'(iobv), 0);
    step(0, 0, 0, 0, 0);
    chk("oor_rvalid", 32'(rvalid), 1);
    chk("oor_err", 32'(err), 1);
    chk("oor_rdata", rdata, 0);
    step(0, 0, 0, 0, 0);
    chk("oor_done_rvalid", 32'(rvalid), 0);

    // Out-of-range fetch held behind bus traffic; in-range fetch held behind the error.
    step(1, 32'h10, 1, 0, 0);
    step(1, 32'hFFFC, 1, 0, 0);
    chk("edge_iobv", 32'(iobv), 1);
    step(1, 32'h0002_0000, 1, 0, 0);
    chk("hold_gnt_a", 32'(gnt), 0);
    step(1, 32'h0002_0000, 1, 1, 32'h5555_0010);
    chk("hold_gnt_b", 32'(gnt), 0);
    step(1, 32'h0002_0000, 1, 1, 32'h5555_FFFC);
    chk("hold_gnt_c", 32'(gnt), 0);
    chk("hold_rdata", rdata, 32'h5555_FFFC);
    step(1, 32'h0002_0000, 1, 0, 0);
    chk("hold_gnt_d", 32'(gnt), 1);
    step(1, 32'h20, 1, 0, 0);
    chk("hold_err_rsp", 32'(err), 1);
    chk("hold_inrange_gnt", 32'(gnt), 0);
    step(1, 32'h20, 1, 0, 0);
    chk("after_err_gnt", 32'(gnt), 1);
    step(0, 0, 0, 1, 32'h7777_0020);
    step(0, 0, 0, 0, 0);

    // Stray response with nothing outstanding.
    step(0, 0, 0, 1, 32'hBAD0_0000);
    chk("stray_rvalid", 32'(rvalid), 0);

    // Reset in the middle of two outstanding fetches.
    step(1, 32'h30, 1, 0, 0);
    step(1, 32'h34, 1, 0, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    req    = 1'b0;
    ready  = 1'b0;
    bus_rv = 1'b0;
    @(negedge clk);
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_iobv", 32'(iobv), 0);
    chk("midrst_rvalid", 32'(rvalid), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    step(0, 0, 0, 1, 32'hBAD0_0030);
    chk("postrst_rvalid", 32'(rvalid), 0);
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ibex_instr_iob_bridge

`default_nettype wire
